// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// The ZERO state is only reachable in builds with DIV_ZERO_DETECT_EN defined.
package div_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2,
        S_ZERO = 2'd3
    } div_state_e;

    localparam int DIV_WIDTH = 32;

    // The iteration counter must be able to hold WIDTH itself.
    function automatic int div_cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

    localparam int DIV_CNT_W = div_cnt_width(DIV_WIDTH);

endpackage : div_pkg

// File: rtl/div_step.sv
// One restoring-division iteration: shift the remainder/quotient register left,
// trial-subtract the divisor from the upper part, and shift in the quotient bit.
module div_step #(
    parameter int WIDTH = div_pkg::DIV_WIDTH
) (
    input  logic [2*WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0]   dsr_i,
    output logic [2*WIDTH-1:0] rem_o
);

    logic [WIDTH:0]   upper;
    logic             fits;
    logic [WIDTH-1:0] diff;

    // The upper half after the shift is WIDTH+1 bits wide: the bit shifted out of
    // the top must join the compare, or large dividends/divisors divide wrongly.
    assign upper = rem_i[2*WIDTH-1:WIDTH-1];
    assign fits  = (upper >= {1'b0, dsr_i});
    // When the divisor fits, the true difference is below 2^WIDTH, so a
    // WIDTH-bit modular subtraction is exact.
    assign diff  = upper[WIDTH-1:0] - dsr_i;

    assign rem_o = fits ? {diff, rem_i[WIDTH-2:0], 1'b1}
                        : {rem_i[2*WIDTH-2:0], 1'b0};

endmodule : div_step

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider with a start/ready handshake.
// Define DIV_ZERO_DETECT_EN to short-cut division by zero through the ZERO state.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic             Busy,
    output logic             Ready,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             DivZero
);

    localparam int CW = div_cnt_width(WIDTH);

    div_state_e       state_q, state_d;
    logic [2*WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0] rem_step;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .dsr_i (dsr_q),
        .rem_o (rem_step)
    );

`ifdef DIV_ZERO_DETECT_EN
    logic divzero_q, divzero_d;
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        rem_d   = rem_q;
        dsr_d   = dsr_q;
        cnt_d   = cnt_q;
`ifdef DIV_ZERO_DETECT_EN
        divzero_d = divzero_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    rem_d   = {{WIDTH{1'b0}}, Dividend};
                    dsr_d   = Divisor;
                    cnt_d   = '0;
                    state_d = S_RUN;
`ifdef DIV_ZERO_DETECT_EN
                    divzero_d = 1'b0;
                    if (Divisor == '0) state_d = S_ZERO;
`endif
                end
            end
            S_RUN: begin
                rem_d = rem_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) state_d = S_DONE;
            end
`ifdef DIV_ZERO_DETECT_EN
            S_ZERO: begin
                // The captured dividend still sits in the lower half.
                rem_d     = {rem_q[WIDTH-1:0], {WIDTH{1'b1}}};
                divzero_d = 1'b1;
                state_d   = S_DONE;
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!Reset) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            dsr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            dsr_q   <= dsr_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef DIV_ZERO_DETECT_EN
    always_ff @(posedge clk) begin
        if (!Reset) divzero_q <= 1'b0;
        else        divzero_q <= divzero_d;
    end
    assign DivZero = divzero_q;
    assign Busy    = (state_q == S_RUN) || (state_q == S_ZERO);
`else
    assign DivZero = 1'b0;
    assign Busy    = (state_q == S_RUN);
`endif

    assign Ready     = (state_q == S_DONE);
    assign Quotient  = rem_q[WIDTH-1:0];
    assign Remainder = rem_q[2*WIDTH-1:WIDTH];

endmodule : seq_divider

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (WIDTH=32), hand-computed results.
// Divide-by-zero expectations follow the DIV_ZERO_DETECT_EN build setting.
module tb_seq_divider;

    logic        clk;
    logic        Reset;
    logic        Start;
    logic [31:0] Dividend;
    logic [31:0] Divisor;
    logic        Busy;
    logic        Ready;
    logic [31:0] Quotient;
    logic [31:0] Remainder;
    logic        DivZero;

    int n_cmp = 0;
    int n_bad = 0;

    seq_divider #(.WIDTH(32)) dut (
        .clk       (clk),
        .Reset     (Reset),
        .Start     (Start),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Busy      (Busy),
        .Ready     (Ready),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .DivZero   (DivZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issues one operation and waits for Ready. lat counts cycles from the Start
    // sample to Ready (inclusive); -1 means Ready never came. If inject_at > 0 a
    // foreign 50/5 Start pulse is driven while busy.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int inject_at,
                          output int lat, output logic [31:0] q, output logic [31:0] r,
                          output logic dz);
        lat = -1;
        q   = '0;
        r   = '0;
        dz  = 1'b0;
        @(negedge clk);
        Start = 1'b1; Dividend = a; Divisor = b;
        @(posedge clk); #1;
        Start = 1'b0; Dividend = 32'hDEAD_BEEF; Divisor = 32'h0000_0011;
        check("busy_after_start", {63'd0, Busy}, 64'd1);
        for (int n = 1; n <= 100; n++) begin
            if (n == inject_at) begin
                Start = 1'b1; Dividend = 32'd50; Divisor = 32'd5;
            end
            @(posedge clk); #1;
            Start = 1'b0;
            if (Ready) begin
                lat = n + 1;
                q   = Quotient;
                r   = Remainder;
                dz  = DivZero;
                break;
            end
        end
        if (lat >= 0) begin
            check("ready_busy_low", {63'd0, Busy}, 64'd0);
            @(posedge clk); #1;
            check("ready_one_cycle", {63'd0, Ready}, 64'd0);
            check("result_held", {Remainder, Quotient}, {r, q});
        end
    endtask

    task automatic div_case(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input int exp_lat, input logic [31:0] exp_q,
                            input logic [31:0] exp_r, input logic exp_dz, input int inject_at);
        int lat;
        logic [31:0] q, r;
        logic dz;
        run_op(a, b, inject_at, lat, q, r, dz);
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_quot"}, {32'd0, q}, {32'd0, exp_q});
        check({tag, "_rem"}, {32'd0, r}, {32'd0, exp_r});
        check({tag, "_divzero"}, {63'd0, dz}, {63'd0, exp_dz});
    endtask

    initial begin
        int readies;
        Reset = 1'b0; Start = 1'b0; Dividend = '0; Divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {63'd0, Busy}, 64'd0);
        check("rst_ready", {63'd0, Ready}, 64'd0);
        check("rst_divzero", {63'd0, DivZero}, 64'd0);
        check("rst_result", {Remainder, Quotient}, 64'd0);
        Reset = 1'b1;
        @(posedge clk); #1;

        div_case("d100_7",   32'd100,        32'd7,          33, 32'd14,        32'd2,          1'b0, 0);
        div_case("dmax_1",   32'hFFFF_FFFF,  32'd1,          33, 32'hFFFF_FFFF, 32'd0,          1'b0, 0);
        div_case("d5_9",     32'd5,          32'd9,          33, 32'd0,         32'd5,          1'b0, 0);
        div_case("dmsb_max", 32'h8000_0000,  32'hFFFF_FFFF,  33, 32'd0,         32'h8000_0000,  1'b0, 0);
        div_case("dmax_big", 32'hFFFF_FFFF,  32'h8000_0001,  33, 32'd1,         32'h7FFF_FFFE,  1'b0, 0);
`ifdef DIV_ZERO_DETECT_EN
        div_case("d1234_0",  32'd1234,       32'd0,          2,  32'hFFFF_FFFF, 32'd1234,       1'b1, 0);
`else
        div_case("d1234_0",  32'd1234,       32'd0,          33, 32'hFFFF_FFFF, 32'd1234,       1'b0, 0);
`endif
        div_case("busy_start", 32'd1000,     32'd3,          33, 32'd333,       32'd1,          1'b0, 10);

        // Reset in the middle of a run: outputs clear, no Ready follows.
        @(negedge clk);
        Start = 1'b1; Dividend = 32'd1000; Divisor = 32'd3;
        @(posedge clk); #1;
        Start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        Reset = 1'b0;
        @(posedge clk); #1;
        check("midrst_busy", {63'd0, Busy}, 64'd0);
        check("midrst_ready", {63'd0, Ready}, 64'd0);
        check("midrst_divzero", {63'd0, DivZero}, 64'd0);
        check("midrst_result", {Remainder, Quotient}, 64'd0);
        Reset = 1'b1;
        readies = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (Ready) readies++;
        end
        check("midrst_no_ready", 64'(readies), 64'd0);

        div_case("d9_2", 32'd9, 32'd2, 33, 32'd4, 32'd1, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_seq_divider
